// File: rtl/bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bank_arbiter
// Description : Round-robin arbiter over the per-bank schedulers with a
//               single registered output stage. Define ROW_HIT_PRIO_EN to
//               prefer open-row hits, limited to MAX_HITS in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_arbiter #(
    parameter int BANKS    = 16,
    parameter int DQ       = 16,
    parameter int IDX      = 6,
    parameter int RA       = 16,
    parameter int CA       = 10,
    parameter int MAX_HITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BANKS-1:0]              valid_i,
    input  logic [BANKS-1:0][DQ-1:0]      dq_i,
    input  logic [BANKS-1:0][IDX-1:0]     idx_i,
    input  logic [BANKS-1:0][RA-1:0]      ra_i,
    input  logic [BANKS-1:0][CA-1:0]      ca_i,
    input  logic [BANKS-1:0]              t_i,
    output logic [BANKS-1:0]              ready_o,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(BANKS)-1:0]      out_bank,
    output logic [DQ-1:0]                 out_dq,
    output logic [IDX-1:0]                out_idx,
    output logic [RA-1:0]                 out_ra,
    output logic [CA-1:0]                 out_ca,
    output logic                          out_t
);

    localparam int c_BW = $clog2(BANKS);

    generate
        if (BANKS < 2 || (BANKS & (BANKS - 1)) != 0) begin : g_banks_check
            $error("bank_arbiter: BANKS must be a power of 2 and at least 2");
        end
        if (MAX_HITS < 1) begin : g_hits_check
            $error("bank_arbiter: MAX_HITS must be at least 1");
        end
    endgenerate

    logic [c_BW-1:0]  r_rr_ptr;
    logic [BANKS-1:0] w_cand;
    logic [c_BW-1:0]  w_winner;
    logic [c_BW-1:0]  w_idx;
    logic             w_found;
    logic             w_en;
    logic             w_grant;

    assign w_en = ~out_valid | out_ready;

`ifdef ROW_HIT_PRIO_EN
    localparam int c_HW = $clog2(MAX_HITS + 1);

    logic [BANKS-1:0][RA-1:0] r_open_row;
    logic [BANKS-1:0]         r_row_vld;
    logic [c_HW-1:0]          r_hit_cnt;
    logic [BANKS-1:0]         w_hit;
    logic                     w_use_hit;

    always_comb begin
        w_hit = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_hit[b] = valid_i[b] & r_row_vld[b] & (ra_i[b] == r_open_row[b]);
        end
    end

    // Hits only win while the streak budget lasts; otherwise every bank competes.
    assign w_use_hit = (|w_hit) && (r_hit_cnt < c_HW'(MAX_HITS));
    assign w_cand    = w_use_hit ? w_hit : valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_open_row <= '0;
            r_row_vld  <= '0;
            r_hit_cnt  <= '0;
        end else if (w_grant) begin
            r_open_row[w_winner] <= ra_i[w_winner];
            r_row_vld[w_winner]  <= 1'b1;
            r_hit_cnt            <= w_use_hit ? r_hit_cnt + 1'b1 : '0;
        end
    end
`else
    assign w_cand = valid_i;
`endif

    // First candidate at or after the round-robin pointer, wrapping modulo BANKS.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        w_idx    = r_rr_ptr;
        for (int i = 0; i < BANKS; i++) begin
            w_idx = r_rr_ptr + c_BW'(i);
            if (!w_found && w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant = w_en & w_found & ~rst;
    assign ready_o = w_grant ? ({{(BANKS-1){1'b0}}, 1'b1} << w_winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            out_valid <= 1'b0;
            out_bank  <= '0;
            out_dq    <= '0;
            out_idx   <= '0;
            out_ra    <= '0;
            out_ca    <= '0;
            out_t     <= 1'b0;
        end else if (w_grant) begin
            r_rr_ptr  <= w_winner + 1'b1;
            out_valid <= 1'b1;
            out_bank  <= w_winner;
            out_dq    <= dq_i[w_winner];
            out_idx   <= idx_i[w_winner];
            out_ra    <= ra_i[w_winner];
            out_ca    <= ca_i[w_winner];
            out_t     <= t_i[w_winner];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_arbiter
// Description : Directed and random checks of bank_arbiter against a
//               rule-level reference model (honours ROW_HIT_PRIO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_arbiter;

    localparam int c_BANKS    = 16;
    localparam int c_MAX_HITS = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [15:0]             valid_i;
    logic [15:0][15:0]       dq_i;
    logic [15:0][5:0]        idx_i;
    logic [15:0][15:0]       ra_i;
    logic [15:0][9:0]        ca_i;
    logic [15:0]             t_i;
    logic [15:0]             ready_o;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0]              out_bank;
    logic [15:0]             out_dq;
    logic [5:0]              out_idx;
    logic [15:0]             out_ra;
    logic [9:0]              out_ca;
    logic                    out_t;

    bank_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .dq_i      (dq_i),
        .idx_i     (idx_i),
        .ra_i      (ra_i),
        .ca_i      (ca_i),
        .t_i       (t_i),
        .ready_o   (ready_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bank  (out_bank),
        .out_dq    (out_dq),
        .out_idx   (out_idx),
        .out_ra    (out_ra),
        .out_ca    (out_ca),
        .out_t     (out_t)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_rr;
    bit          m_ov;
    int          m_bank;
    logic [48:0] m_fields;
    bit          m_known = 1'b0;
    int          m_hit_cnt;
    logic [15:0] m_open_row [c_BANKS];
    bit          m_row_vld  [c_BANKS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] fields_of(input int b);
        return {dq_i[b], idx_i[b], ra_i[b], ca_i[b], t_i[b]};
    endfunction

    // One clock: predict the grant, compare, then advance the model across the edge.
    task automatic step(input bit use_want, input logic [15:0] want);
        logic [15:0] cand;
        logic [15:0] exp_ready;
        bit          hit_mode;
        int          win;
        @(negedge clk);
        exp_ready = '0;
        hit_mode  = 1'b0;
        win       = -1;
        if (!rst && (!m_ov || out_ready)) begin
            cand = valid_i;
`ifdef ROW_HIT_PRIO_EN
            begin
                logic [15:0] hits;
                hits = '0;
                for (int b = 0; b < c_BANKS; b++)
                    if (valid_i[b] && m_row_vld[b] && ra_i[b] == m_open_row[b]) hits[b] = 1'b1;
                if (hits != 0 && m_hit_cnt < c_MAX_HITS) begin
                    cand     = hits;
                    hit_mode = 1'b1;
                end
            end
`endif
            for (int k = 0; k < c_BANKS; k++) begin
                int b;
                b = (m_rr + k) % c_BANKS;
                if (cand[b]) begin
                    win = b;
                    break;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
        end
        check("ready_o", ready_o, exp_ready);
        if (use_want) check("ready_directed", ready_o, want);
        if (m_known) begin
            check("out_valid", out_valid, m_ov);
            if (m_ov) begin
                check("out_bank", out_bank, m_bank);
                check("out_fields", {out_dq, out_idx, out_ra, out_ca, out_t}, m_fields);
            end
        end

        if (rst) begin
            m_known   = 1'b1;
            m_rr      = 0;
            m_ov      = 1'b0;
            m_bank    = 0;
            m_fields  = '0;
            m_hit_cnt = 0;
            for (int b = 0; b < c_BANKS; b++) begin
                m_open_row[b] = '0;
                m_row_vld[b]  = 1'b0;
            end
        end else if (win >= 0) begin
            m_ov            = 1'b1;
            m_bank          = win;
            m_fields        = fields_of(win);
            m_rr            = (win + 1) % c_BANKS;
            m_open_row[win] = ra_i[win];
            m_row_vld[win]  = 1'b1;
            m_hit_cnt       = hit_mode ? m_hit_cnt + 1 : 0;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_fields();
        for (int b = 0; b < c_BANKS; b++) begin
            dq_i[b]  = 16'($urandom);
            idx_i[b] = 6'($urandom);
            ra_i[b]  = 16'($urandom_range(0, 3));
            ca_i[b]  = 10'($urandom);
            t_i[b]   = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid_i   = '0;
        out_ready = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        valid_i   = '0;
        out_ready = 1'b1;
        randomize_fields();
        do_reset();

        // Reset state
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_fields", {out_bank, out_dq, out_idx, out_ra, out_ca, out_t}, '0);

        // All banks requesting: 0..15 then wrap to 0
        valid_i = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            logic [15:0] w;
            w = 16'h0001 << (i % 16);
            randomize_fields();
            step(1'b1, w);
        end

        // Wrap-around from rr_ptr=1
        do_reset();
        valid_i = 16'h0001;
        step(1'b1, 16'h0001);
        valid_i = 16'h8001;
        step(1'b1, 16'h8000);
        step(1'b1, 16'h0001);

        // Backpressure hold then release
        valid_i   = 16'h0F0F;
        out_ready = 1'b0;
        step(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            randomize_fields();
            step(1'b1, 16'h0000);
        end
        out_ready = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);

        // Single bank 5 with fixed fields
        valid_i   = 16'h0000;
        step(1'b1, 16'h0000);
        step(1'b0, '0);
        valid_i   = 16'h0020;
        ra_i[5]   = 16'h0012;
        ca_i[5]   = 10'h003;
        t_i[5]    = 1'b1;
        idx_i[5]  = 6'd9;
        step(1'b1, 16'h0020);
        valid_i = 16'h0000;
        step(1'b1, 16'h0000);
        check("t4_bank_ra", {out_bank, out_ra}, {4'd5, 16'h0012});

        // Reset while holding a request
        valid_i   = 16'h00F0;
        out_ready = 1'b0;
        step(1'b0, '0);
        rst = 1'b1;
        step(1'b1, 16'h0000);
        rst       = 1'b0;
        out_ready = 1'b1;
        valid_i   = 16'hFFFF;
        step(1'b1, 16'h0001);

`ifdef ROW_HIT_PRIO_EN
        // Row-hit streak capped at MAX_HITS
        do_reset();
        ra_i[3] = 16'h0040;
        ra_i[1] = 16'h0011;
        valid_i = 16'h0008;
        step(1'b1, 16'h0008);
        valid_i = 16'h000A;
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0008);
        step(1'b1, 16'h0002);
        step(1'b1, 16'h0008);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            randomize_fields();
            valid_i   = 16'($urandom) & 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            step(1'b0, '0);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
